// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the TX burst framer.
// Define TX_BURST_FRAMER_CRC_EN to add the CRC-16 trailer word and its state.
package tx_framer_pkg;

    localparam logic [15:0] CRC_POLY              = 16'h1021;
    localparam logic [15:0] CRC_INIT              = 16'hFFFF;
    localparam logic [31:0] DEFAULT_PREAMBLE_WORD = 32'h7FFF_8001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
`ifdef TX_BURST_FRAMER_CRC_EN
        ST_CRC,
`endif
        ST_GUARD
    } state_t;

`ifdef TX_BURST_FRAMER_CRC_EN
    // CRC-16-CCITT advanced over one 32-bit word, most significant bit first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (crc[15] ^ data[i]) begin
                crc = {crc[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc = {crc[14:0], 1'b0};
            end
        end
        return crc;
    endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO on an inferred RAM; rd_data always presents the current head
// one cycle after it is written, with a bypass when the head slot is written.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q;
    logic             push, pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = head_q;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Read address is the next head so the registered output tracks pops without a bubble.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_q <= wr_data;
        end else begin
            head_q <= mem[rd_ptr_d];
        end
    end

endmodule

// File: rtl/tx_burst_framer.sv
// Frames buffered I/Q samples into preamble + payload (+ CRC) + guard bursts.
// Optional CRC trailer enabled by defining TX_BURST_FRAMER_CRC_EN.
module tx_burst_framer
    import tx_framer_pkg::*;
#(
    parameter int          PREAMBLE_LEN  = 8,
    parameter int          PAYLOAD_LEN   = 32,
    parameter int          GUARD_LEN     = 4,
    parameter int          FIFO_DEPTH    = 64,
    parameter logic [31:0] PREAMBLE_WORD = DEFAULT_PREAMBLE_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_iq,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_iq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] burst_count
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] PAY_THRESH = CW'(PAYLOAD_LEN);
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0] GRD_LAST  = 16'(GUARD_LEN - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   out_iq_q, out_iq_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          out_eof_q, out_eof_d;
    logic [15:0]   burst_count_q, burst_count_d;
`ifdef TX_BURST_FRAMER_CRC_EN
    logic [15:0]   crc_q, crc_d;
`endif

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [31:0]   fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          load, take_sample, enter_tail;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid),
        .wr_data (in_iq),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready    = !fifo_full;
    assign out_iq      = out_iq_q;
    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign burst_count = burst_count_q;

    // The output register is refilled whenever it is empty or its word is being taken.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_iq_d      = out_iq_q;
        out_valid_d   = out_valid_q;
        out_sof_d     = out_sof_q;
        out_eof_d     = out_eof_q;
        burst_count_d = burst_count_q;
`ifdef TX_BURST_FRAMER_CRC_EN
        crc_d         = crc_q;
`endif
        fifo_pop      = 1'b0;
        take_sample   = 1'b0;
        enter_tail    = 1'b0;

        if (out_valid_q && out_ready && out_eof_q) begin
            burst_count_d = burst_count_q + 16'd1;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            out_iq_d    = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && (fifo_count >= PAY_THRESH)) begin
                        state_d   = ST_PREAMBLE;
                        cnt_d     = '0;
                        out_iq_d  = PREAMBLE_WORD;
                        out_sof_d = 1'b1;
`ifdef TX_BURST_FRAMER_CRC_EN
                        crc_d     = CRC_INIT;
`endif
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d     = ST_PAYLOAD;
                        cnt_d       = '0;
                        take_sample = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 16'd1;
                        out_iq_d = cnt_d[0] ? ~PREAMBLE_WORD : PREAMBLE_WORD;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q == PAY_LAST) begin
`ifdef TX_BURST_FRAMER_CRC_EN
                        state_d   = ST_CRC;
                        out_iq_d  = {crc_q, 16'h0000};
                        out_eof_d = 1'b1;
`else
                        enter_tail = 1'b1;
`endif
                    end else begin
                        cnt_d       = cnt_q + 16'd1;
                        take_sample = 1'b1;
                    end
                end
`ifdef TX_BURST_FRAMER_CRC_EN
                ST_CRC: begin
                    enter_tail = 1'b1;
                end
`endif
                ST_GUARD: begin
                    if (cnt_q == GRD_LAST) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase

            if (take_sample) begin
                fifo_pop = 1'b1;
                out_iq_d = fifo_rd_data;
`ifdef TX_BURST_FRAMER_CRC_EN
                crc_d     = crc16_word(crc_q, fifo_rd_data);
`else
                out_eof_d = (cnt_d == PAY_LAST);
`endif
            end

            if (enter_tail) begin
                cnt_d = '0;
                if (GUARD_LEN == 0) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_GUARD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            out_iq_q      <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            burst_count_q <= '0;
`ifdef TX_BURST_FRAMER_CRC_EN
            crc_q         <= CRC_INIT;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_iq_q      <= out_iq_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_eof_q     <= out_eof_d;
            burst_count_q <= burst_count_d;
`ifdef TX_BURST_FRAMER_CRC_EN
            crc_q         <= crc_d;
`endif
        end
    end

endmodule

// File: doc/tx_burst_framer.md
TX_BURST_FRAMER -- requirements
Module: tx_burst_framer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 8, number of preamble words per burst (range 2..255).
REQ-002 Parameter PAYLOAD_LEN, default 32, number of I/Q samples per burst (range 1..FIFO_DEPTH).
REQ-003 Parameter GUARD_LEN, default 4, number of zero words after each burst (range 0..255).
REQ-004 Parameter FIFO_DEPTH, default 64, input buffer depth in samples (power of 2).
REQ-005 Parameter PREAMBLE_WORD, default 32'h7FFF_8001, even-index preamble pattern.
REQ-006 Port clk  in  1  single clock; all logic on its rising edge.
REQ-007 Port reset  in  1  reset is synchronous and active-high.
REQ-008 Port in_iq  in  32  modulator output sample: I in [31:16], Q in [15:0], both signed.
REQ-009 Port in_valid  in  1  in_iq holds a valid sample.
REQ-010 Port in_ready  out  1  framer accepts a sample this cycle.
REQ-011 Port out_iq  out  32  framed output word.
REQ-012 Port out_valid  out  1  out_iq holds a valid word.
REQ-013 Port out_ready  in  1  downstream accepts a word this cycle.
REQ-014 Port out_sof  out  1  marks the first preamble word of a burst.
REQ-015 Port out_eof  out  1  marks the last data-carrying word of a burst.
REQ-016 Port burst_count  out  16  number of completed bursts.

Function
REQ-017 Input push occurs when in_valid and in_ready are both high; in_ready is high exactly when the FIFO is not full.
REQ-018 Output beat occurs when out_valid and out_ready are both high; out_iq, out_sof and out_eof are held stable while out_valid is high and out_ready is low.
REQ-019 The FSM has the states IDLE, PREAMBLE, PAYLOAD, CRC and GUARD.
REQ-020 IDLE -> PREAMBLE when FIFO occupancy >= PAYLOAD_LEN; out_valid rises on the next cycle.
REQ-021 PREAMBLE emits PREAMBLE_LEN words alternating PREAMBLE_WORD and ~PREAMBLE_WORD, starting with PREAMBLE_WORD; out_sof is high on the first word only.
REQ-022 PAYLOAD pops exactly one FIFO sample per output beat, for PAYLOAD_LEN beats, in arrival order.
REQ-023 GUARD emits GUARD_LEN words of 32'h0 with out_valid high, then returns to IDLE; with GUARD_LEN=0 the FSM goes straight to IDLE.
REQ-024 burst_count increments by 1 on the beat carrying out_eof and wraps from 16'hFFFF to 0.
REQ-025 A push and a pop in the same cycle leave occupancy unchanged, including at full and at PAYLOAD_LEN threshold.
REQ-026 Input continues to be accepted during all FSM states while the FIFO is not full.
REQ-027 out_valid is low in IDLE.

Reset
REQ-028 Reset mid-burst aborts the burst immediately, empties the FIFO, and discards partial output without asserting out_eof.
REQ-029 Reset values: out_iq=0, out_valid=0, out_sof=0, out_eof=0, burst_count=0, in_ready=1 on the first cycle after reset deasserts, FSM=IDLE.

Configuration
REQ-030 With TX_BURST_FRAMER_CRC_EN defined, PAYLOAD -> CRC, and CRC emits one word {crc16, 16'h0000} with out_eof high.
REQ-031 The CRC is CRC-16-CCITT: polynomial 0x1021, initial value 0xFFFF, computed MSB-first over all 32 bits of each payload word, and reset at sof.
REQ-032 Without TX_BURST_FRAMER_CRC_EN, the CRC state and logic are absent, PAYLOAD -> GUARD, and out_eof is on the last payload word.

Structure
REQ-033 Package tx_framer_pkg holds the FSM state enum, CRC_POLY, CRC_INIT and the default PREAMBLE_WORD.
REQ-034 The buffer is a sub-module sync_fifo (parameterised width and depth, with full, empty and count outputs).

Verification
REQ-035 Push 32 samples 32'h0001_0001..32'h0020_0020 with out_ready=1 -> output is 8 preamble words (7FFF8001, 80007FFE, ...), then the 32 samples in order, then 4 zero words; burst_count=1.
REQ-036 Hold out_ready=0 for 10 cycles mid-payload -> out_iq stays stable, no sample is lost or duplicated, and the FIFO fills until in_ready=0 at 64 entries.
REQ-037 Drive 96 samples continuously -> 3 back-to-back bursts with one sof and one eof each; burst_count=3.
REQ-038 With CRC_EN, payload of 32 words of 32'h0 -> the CRC word equals the reference-model CRC-16-CCITT value in [31:16] and has out_eof high.
REQ-039 Assert reset at payload beat 10 -> next cycle out_valid=0, FIFO is empty, and burst_count is unchanged; a fresh 32-sample load then yields a correct burst.
